// File: rtl/thr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : thr_pkg
//  Description : Shared phase codes and frame-size defaults for the
//                adaptive-thresholding pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package thr_pkg;

    localparam int c_STATE_W = 3;

    // global_state carries these codes directly; the filter stage keys on ST_FILTER
    localparam logic [c_STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] ST_FILTER = 3'd1;
    localparam logic [c_STATE_W-1:0] ST_SHOW   = 3'd2;
    localparam logic [c_STATE_W-1:0] ST_LOAD   = 3'd3;
    localparam logic [c_STATE_W-1:0] ST_PREP   = 3'd4;

    localparam int c_DEF_WIDTH_BITS  = 8;
    localparam int c_DEF_HEIGHT_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/mem_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_mux
//  Description : Combinational address/data/write-enable selector for one
//                memory port with two state-keyed owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_mux
    import thr_pkg::*;
#(
    parameter int                   COL_BITS = c_DEF_WIDTH_BITS,
    parameter int                   ROW_BITS = c_DEF_HEIGHT_BITS,
    parameter logic [c_STATE_W-1:0] OWNER_A  = ST_LOAD,
    parameter logic [c_STATE_W-1:0] OWNER_B  = ST_FILTER
) (
    input  logic [c_STATE_W-1:0] i_state,
    input  logic                 i_kill,
    input  logic [COL_BITS-1:0]  i_a_col,
    input  logic [ROW_BITS-1:0]  i_a_row,
    input  logic [7:0]           i_a_wdata,
    input  logic                 i_a_wren,
    input  logic [COL_BITS-1:0]  i_b_col,
    input  logic [ROW_BITS-1:0]  i_b_row,
    input  logic [7:0]           i_b_wdata,
    input  logic                 i_b_wren,
    output logic [COL_BITS-1:0]  o_col,
    output logic [ROW_BITS-1:0]  o_row,
    output logic [7:0]           o_wdata,
    output logic                 o_wren
);

    // A port with no owner in the current phase presents all zeros
    always_comb begin
        o_col   = '0;
        o_row   = '0;
        o_wdata = '0;
        o_wren  = 1'b0;
        if (i_state == OWNER_A) begin
            o_col   = i_a_col;
            o_row   = i_a_row;
            o_wdata = i_a_wdata;
            o_wren  = i_a_wren & ~i_kill;
        end else if (i_state == OWNER_B) begin
            o_col   = i_b_col;
            o_row   = i_b_row;
            o_wdata = i_b_wdata;
            o_wren  = i_b_wren & ~i_kill;
        end
    end

endmodule
`default_nettype wire

// File: rtl/thresh_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : thresh_sequencer
//  Description : Phase controller for the adaptive-thresholding pipeline:
//                load, filter prep, filter run, display; arbitrates memories.
//  Revision    : 1.0 - initial release
// ============================================================================
module thresh_sequencer
    import thr_pkg::*;
#(
    parameter int WIDTH_BITS  = c_DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = c_DEF_HEIGHT_BITS,
    parameter int NPIX        = 2**(WIDTH_BITS+HEIGHT_BITS),
    parameter int PREP_CYCLES = 2,
    parameter int TIMEOUT     = 2**20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_req,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4:0]             c_in,
    input  logic                   load_valid,
    input  logic [7:0]             load_data,
    output logic                   load_ready,
    output logic [2:0]             global_state,
    output logic                   filter_not_reset,
    output logic [4:0]             filter_C,
    input  logic                   filter_finished,
    input  logic [WIDTH_BITS-1:0]  f_img_col,
    input  logic [HEIGHT_BITS-1:0] f_img_row,
    input  logic [WIDTH_BITS-1:0]  f_res_col,
    input  logic [HEIGHT_BITS-1:0] f_res_row,
    input  logic [7:0]             f_res_data,
    input  logic                   f_res_wren,
    input  logic [WIDTH_BITS-1:0]  d_col,
    input  logic [HEIGHT_BITS-1:0] d_row,
    output logic [WIDTH_BITS-1:0]  img_col,
    output logic [HEIGHT_BITS-1:0] img_row,
    output logic [7:0]             img_wdata,
    output logic                   img_wren,
    output logic [WIDTH_BITS-1:0]  res_col,
    output logic [HEIGHT_BITS-1:0] res_row,
    output logic [7:0]             res_wdata,
    output logic                   res_wren,
    output logic                   loaded,
    output logic                   done,
    output logic                   error
);

    localparam int c_PIX_W  = WIDTH_BITS + HEIGHT_BITS;
    localparam int c_WD_W   = $clog2(TIMEOUT);
    localparam int c_PREP_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;

    localparam logic [c_PIX_W-1:0]  c_LAST_PIX  = c_PIX_W'(NPIX - 1);
    localparam logic [c_WD_W-1:0]   c_WD_LAST   = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_PREP_W-1:0] c_PREP_LAST = c_PREP_W'(PREP_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_PIX_W-1:0]   r_load_cnt;
    logic [c_WD_W-1:0]    r_wd_cnt;
    logic [c_PREP_W-1:0]  r_prep_cnt;
    logic [4:0]           r_filter_c;
    logic                 r_loaded;
    logic                 r_done;
    logic                 r_error;

    logic w_load_last;
    logic w_prep_last;
    logic w_wd_last;
    logic w_enter_load;
    logic w_enter_prep;

    assign w_load_last  = (r_state == ST_LOAD) && load_valid && (r_load_cnt == c_LAST_PIX);
    assign w_prep_last  = (r_prep_cnt == c_PREP_LAST);
    assign w_wd_last    = (r_wd_cnt == c_WD_LAST);
    assign w_enter_load = (r_state != ST_LOAD) && (w_next_state == ST_LOAD);
    assign w_enter_prep = (r_state != ST_PREP) && (w_next_state == ST_PREP);

    // Requests arriving during LOAD/PREP/FILTER are dropped, not queued
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (load_req)
                        w_next_state = ST_LOAD;
                    else if (start && r_loaded)
                        w_next_state = ST_PREP;
                end
                ST_LOAD: begin
                    if (w_load_last)
                        w_next_state = ST_IDLE;
                end
                ST_PREP: begin
                    if (w_prep_last)
                        w_next_state = ST_FILTER;
                end
                ST_FILTER: begin
                    if (filter_finished)
                        w_next_state = ST_SHOW;
                    else if (w_wd_last)
                        w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_load_cnt <= '0;
            r_wd_cnt   <= '0;
            r_prep_cnt <= '0;
            r_filter_c <= '0;
            r_loaded   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Exact-width counter: the final pixel's increment wraps it to 0
            if ((r_state == ST_LOAD) && !abort) begin
                if (load_valid)
                    r_load_cnt <= r_load_cnt + 1'b1;
            end else begin
                r_load_cnt <= '0;
            end

            if ((r_state == ST_PREP) && !abort)
                r_prep_cnt <= r_prep_cnt + 1'b1;
            else
                r_prep_cnt <= '0;

            if ((r_state == ST_FILTER) && (w_next_state == ST_FILTER))
                r_wd_cnt <= r_wd_cnt + 1'b1;
            else
                r_wd_cnt <= '0;

            if (w_enter_load) begin
                r_loaded <= 1'b0;
                r_done   <= 1'b0;
                r_error  <= 1'b0;
            end

            if (w_enter_prep) begin
                r_filter_c <= c_in;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
            end

            if (w_load_last && !abort)
                r_loaded <= 1'b1;

            if ((r_state == ST_FILTER) && !abort) begin
                if (filter_finished)
                    r_done <= 1'b1;
                else if (w_wd_last)
                    r_error <= 1'b1;
            end
        end
    end

    assign global_state     = r_state;
    assign load_ready       = (r_state == ST_LOAD);
    assign filter_not_reset = ((r_state == ST_FILTER) || (r_state == ST_SHOW)) && !abort;
    assign filter_C         = r_filter_c;
    assign loaded           = r_loaded;
    assign done             = r_done;
    assign error            = r_error;

    mem_port_mux #(
        .COL_BITS (WIDTH_BITS),
        .ROW_BITS (HEIGHT_BITS),
        .OWNER_A  (ST_LOAD),
        .OWNER_B  (ST_FILTER)
    ) u_img_mux (
        .i_state   (r_state),
        .i_kill    (abort),
        .i_a_col   (r_load_cnt[WIDTH_BITS-1:0]),
        .i_a_row   (r_load_cnt[c_PIX_W-1:WIDTH_BITS]),
        .i_a_wdata (load_data),
        .i_a_wren  (load_valid),
        .i_b_col   (f_img_col),
        .i_b_row   (f_img_row),
        .i_b_wdata (8'd0),
        .i_b_wren  (1'b0),
        .o_col     (img_col),
        .o_row     (img_row),
        .o_wdata   (img_wdata),
        .o_wren    (img_wren)
    );

    mem_port_mux #(
        .COL_BITS (WIDTH_BITS),
        .ROW_BITS (HEIGHT_BITS),
        .OWNER_A  (ST_FILTER),
        .OWNER_B  (ST_SHOW)
    ) u_res_mux (
        .i_state   (r_state),
        .i_kill    (abort),
        .i_a_col   (f_res_col),
        .i_a_row   (f_res_row),
        .i_a_wdata (f_res_data),
        .i_a_wren  (f_res_wren),
        .i_b_col   (d_col),
        .i_b_row   (d_row),
        .i_b_wdata (8'd0),
        .i_b_wren  (1'b0),
        .o_col     (res_col),
        .o_row     (res_row),
        .o_wdata   (res_wdata),
        .o_wren    (res_wren)
    );

endmodule
`default_nettype wire

// File: tb/tb_thresh_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thresh_sequencer
//  Description : Directed/randomized bench for thresh_sequencer against a
//                phase-level reference model (2x2-bit frame, timeout 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thresh_sequencer;

    localparam int WB = 2;
    localparam int HB = 2;
    localparam int NP = 16;
    localparam int PC = 2;
    localparam int TO = 256;

    logic          clock, reset, load_req, start, abort;
    logic [4:0]    c_in;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic [2:0]    global_state;
    logic          filter_not_reset;
    logic [4:0]    filter_C;
    logic          filter_finished;
    logic [WB-1:0] f_img_col, f_res_col, d_col, img_col, res_col;
    logic [HB-1:0] f_img_row, f_res_row, d_row, img_row, res_row;
    logic [7:0]    f_res_data, img_wdata, res_wdata;
    logic          f_res_wren, img_wren, res_wren;
    logic          loaded, done, error;

    thresh_sequencer #(
        .WIDTH_BITS (WB), .HEIGHT_BITS (HB), .NPIX (NP),
        .PREP_CYCLES (PC), .TIMEOUT (TO)
    ) dut (
        .clock (clock), .reset (reset), .load_req (load_req), .start (start),
        .abort (abort), .c_in (c_in), .load_valid (load_valid), .load_data (load_data),
        .load_ready (load_ready), .global_state (global_state),
        .filter_not_reset (filter_not_reset), .filter_C (filter_C),
        .filter_finished (filter_finished),
        .f_img_col (f_img_col), .f_img_row (f_img_row),
        .f_res_col (f_res_col), .f_res_row (f_res_row),
        .f_res_data (f_res_data), .f_res_wren (f_res_wren),
        .d_col (d_col), .d_row (d_row),
        .img_col (img_col), .img_row (img_row), .img_wdata (img_wdata), .img_wren (img_wren),
        .res_col (res_col), .res_row (res_row), .res_wdata (res_wdata), .res_wren (res_wren),
        .loaded (loaded), .done (done), .error (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Phase-level model: 0 idle, 1 filter, 2 show, 3 load, 4 prep
    int m_state, m_pix, m_prep, m_fcyc, m_c;
    bit m_loaded, m_done, m_error;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = 0; m_pix = 0; m_prep = 0; m_fcyc = 0; m_c = 0;
            m_loaded = 0; m_done = 0; m_error = 0;
            return;
        end
        if (abort) begin
            m_state = 0; m_pix = 0; m_prep = 0; m_fcyc = 0;
            return;
        end
        case (m_state)
            0, 2: begin
                if (load_req) begin
                    m_state = 3; m_pix = 0; m_loaded = 0; m_done = 0; m_error = 0;
                end else if (start && m_loaded) begin
                    m_state = 4; m_prep = 0; m_c = int'(c_in); m_done = 0; m_error = 0;
                end
            end
            3: if (load_valid) begin
                m_pix++;
                if (m_pix == NP) begin
                    m_pix = 0; m_loaded = 1; m_state = 0;
                end
            end
            4: begin
                m_prep++;
                if (m_prep == PC) begin
                    m_state = 1; m_fcyc = 0;
                end
            end
            1: begin
                m_fcyc++;
                if (filter_finished) begin
                    m_state = 2; m_done = 1;
                end else if (m_fcyc == TO) begin
                    m_state = 0; m_error = 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ecol, erow, ewd, ewr, rcol, rrow, rwd, rwr;
        ecol = 0; erow = 0; ewd = 0; ewr = 0;
        rcol = 0; rrow = 0; rwd = 0; rwr = 0;
        if (m_state == 3) begin
            ecol = 32'(m_pix % (1 << WB));
            erow = 32'(m_pix >> WB);
            ewd  = 32'(load_data);
            ewr  = 32'(load_valid & ~abort);
        end else if (m_state == 1) begin
            ecol = 32'(f_img_col);
            erow = 32'(f_img_row);
        end
        if (m_state == 1) begin
            rcol = 32'(f_res_col);
            rrow = 32'(f_res_row);
            rwd  = 32'(f_res_data);
            rwr  = 32'(f_res_wren & ~abort);
        end else if (m_state == 2) begin
            rcol = 32'(d_col);
            rrow = 32'(d_row);
        end
        chk({tag, ":global_state"}, 32'(global_state), 32'(m_state));
        chk({tag, ":load_ready"}, 32'(load_ready), 32'(m_state == 3));
        chk({tag, ":filter_not_reset"}, 32'(filter_not_reset),
            32'(((m_state == 1) || (m_state == 2)) && !abort));
        chk({tag, ":filter_C"}, 32'(filter_C), 32'(m_c));
        chk({tag, ":loaded"}, 32'(loaded), 32'(m_loaded));
        chk({tag, ":done"}, 32'(done), 32'(m_done));
        chk({tag, ":error"}, 32'(error), 32'(m_error));
        chk({tag, ":img_col"}, 32'(img_col), ecol);
        chk({tag, ":img_row"}, 32'(img_row), erow);
        chk({tag, ":img_wdata"}, 32'(img_wdata), ewd);
        chk({tag, ":img_wren"}, 32'(img_wren), ewr);
        chk({tag, ":res_col"}, 32'(res_col), rcol);
        chk({tag, ":res_row"}, 32'(res_row), rrow);
        chk({tag, ":res_wdata"}, 32'(res_wdata), rwd);
        chk({tag, ":res_wren"}, 32'(res_wren), rwr);
    endtask

    task automatic rand_side();
        f_img_col  = WB'($urandom);
        f_img_row  = HB'($urandom);
        f_res_col  = WB'($urandom);
        f_res_row  = HB'($urandom);
        f_res_data = 8'($urandom);
        f_res_wren = 1'($urandom);
        d_col      = WB'($urandom);
        d_row      = HB'($urandom);
    endtask

    // Inputs are set just after a rising edge; outputs are checked 1 time unit later
    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic rcyc(input string tag);
        rand_side();
        cyc(tag);
    endtask

    task automatic load_frame(input bit by_index);
        int budget;
        load_req = 1'b1;
        rcyc("load_req");
        load_req = 1'b0;
        budget = 0;
        while (m_state == 3 && budget < 200) begin
            load_valid = by_index ? 1'b1 : ($urandom_range(0, 3) != 0);
            load_data  = by_index ? 8'(m_pix) : 8'($urandom);
            if (!by_index) begin
                start    = 1'($urandom);
                load_req = 1'($urandom);
            end
            rcyc(by_index ? "load_idx" : "load_rand");
            budget++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
        load_req   = 1'b0;
        chk("frame_loaded_flag", 32'(loaded), 32'd1);
        chk("frame_back_idle", 32'(global_state), 32'd0);
    endtask

    task automatic begin_run(input logic [4:0] c);
        int budget;
        start = 1'b1;
        c_in  = c;
        rcyc("start");
        start = 1'b0;
        c_in  = 5'($urandom);
        budget = 0;
        while (m_state == 4 && budget < 10) begin
            rcyc("prep");
            budget++;
        end
    endtask

    initial begin
        reset = 1'b1; load_req = 1'b0; start = 1'b0; abort = 1'b0;
        c_in = 5'd0; load_valid = 1'b0; load_data = 8'd0; filter_finished = 1'b0;
        rand_side();
        m_state = 0; m_pix = 0; m_prep = 0; m_fcyc = 0; m_c = 0;
        m_loaded = 0; m_done = 0; m_error = 0;
        @(posedge clock);
        model_step();
        #1;
        rcyc("reset");
        rcyc("reset");
        reset = 1'b0;
        rcyc("post_reset");

        // start with no frame is ignored
        start = 1'b1; c_in = 5'd9;
        rcyc("start_nofr");
        start = 1'b0;
        rcyc("start_nofr_idle");
        chk("nofr_state", 32'(global_state), 32'd0);

        load_frame(1'b1);

        begin_run(5'd5);
        chk("run_filter_C", 32'(filter_C), 32'd5);
        for (int i = 0; i < 6; i++) rcyc("filter");
        filter_finished = 1'b1;
        rcyc("finish");
        filter_finished = 1'b0;
        for (int i = 0; i < 4; i++) rcyc("show");
        chk("show_done", 32'(done), 32'd1);

        // load_req outranks start in SHOW
        load_req = 1'b1; start = 1'b1;
        rcyc("show_pri");
        load_req = 1'b0; start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1; load_data = 8'($urandom);
            rcyc("pre_abort");
        end
        abort = 1'b1;
        rcyc("abort_load");
        abort = 1'b0;
        for (int i = 0; i < 3; i++) rcyc("post_abort");
        load_valid = 1'b0;
        chk("abort_loaded", 32'(loaded), 32'd0);

        load_frame(1'b0);

        // watchdog expiry
        begin_run(5'($urandom));
        filter_finished = 1'b0;
        for (int i = 0; i < 300 && m_state == 1; i++) rcyc("watchdog");
        chk("to_error", 32'(error), 32'd1);
        chk("to_state", 32'(global_state), 32'd0);

        // finished on the timeout cycle wins
        begin_run(5'($urandom));
        for (int i = 0; i < TO - 1; i++) rcyc("wd_near");
        filter_finished = 1'b1;
        rcyc("fin_on_to");
        filter_finished = 1'b0;
        chk("fin_on_to_state", 32'(global_state), 32'd2);
        chk("fin_on_to_error", 32'(error), 32'd0);

        // abort in FILTER masks the result write
        begin_run(5'($urandom));
        rcyc("filter2");
        rand_side();
        f_res_wren = 1'b1;
        abort = 1'b1;
        cyc("abort_filter");
        abort = 1'b0;
        rcyc("after_abort_filter");

        // reset mid-FILTER
        begin_run(5'd17);
        for (int i = 0; i < 3; i++) rcyc("filter3");
        reset = 1'b1;
        rcyc("rst_mid_filter");
        reset = 1'b0;
        rcyc("after_rst");
        chk("rst_filter_C", 32'(filter_C), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);

        // reset mid-LOAD
        load_req = 1'b1;
        rcyc("load_req2");
        load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = 8'($urandom);
            rcyc("load_part");
        end
        reset = 1'b1;
        rcyc("rst_mid_load");
        reset = 1'b0;
        load_valid = 1'b0;
        rcyc("after_rst2");
        chk("rst_load_state", 32'(global_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
